// File: rtl/imm_gen_stage_pkg.sv
// Shared defines for the immediate-generation stage: format codes, type bus
// and instruction bus types.
package imm_gen_stage_pkg;

  localparam int unsigned TYPE_W = 3;
  localparam int unsigned INST_W = 32;

  typedef logic [TYPE_W-1:0] type_bus_t;
  typedef logic [INST_W-1:0] reg_bus_t;

  localparam type_bus_t INST_R   = 3'd0;
  localparam type_bus_t INST_I   = 3'd1;
  localparam type_bus_t INST_S   = 3'd2;
  localparam type_bus_t INST_B   = 3'd3;
  localparam type_bus_t INST_U   = 3'd4;
  localparam type_bus_t INST_J   = 3'd5;
  localparam type_bus_t INST_CSR = 3'd6;

endpackage

// File: rtl/imm_gen_stage_decode.sv
// imm_fmt_decode: combinational immediate extraction by format code.
// Optional macro IMM_GEN_ZICSR_EN enables the CSR (uimm) format.
module imm_fmt_decode
  import imm_gen_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  reg_bus_t          in_inst,
  input  type_bus_t         in_type,
  output logic [XLEN-1:0]   imm,
  output logic              err
);

  logic [31:0] imm32;
  logic        unused_opcode;

  assign unused_opcode = ^in_inst[6:0];

  // Build a 32-bit value already extended from the format's top bit; CSR uimm has bit 31 clear.
  always_comb begin
    imm32 = '0;
    err   = 1'b0;
    case (in_type)
      INST_R: imm32 = '0;
      INST_I: imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      INST_S: imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      INST_B: imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                       in_inst[11:8], 1'b0};
      INST_U: imm32 = {in_inst[31:12], 12'b0};
      INST_J: imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                       in_inst[30:21], 1'b0};
`ifdef IMM_GEN_ZICSR_EN
      INST_CSR: imm32 = {27'b0, in_inst[19:15]};
`endif
      default: begin
        imm32 = '0;
        err   = 1'b1;
      end
    endcase
  end

  // Sign-extend bit 31 to the result width.
  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: decodes immediates at push time into a DEPTH-entry FIFO.
// Optional macro IMM_GEN_ZICSR_EN (see imm_fmt_decode) enables the CSR format.
module imm_gen_stage
  import imm_gen_stage_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  reg_bus_t        in_inst,
  input  type_bus_t       in_type,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output type_bus_t       out_type,
  output logic            out_err
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;

  logic [XLEN-1:0]  dec_imm;
  logic             dec_err;

  logic [XLEN-1:0]  imm_mem_q  [DEPTH];
  type_bus_t        type_mem_q [DEPTH];
  logic             err_mem_q  [DEPTH];

  imm_fmt_decode #(.XLEN(XLEN)) u_decode (
    .in_inst (in_inst),
    .in_type (in_type),
    .imm     (dec_imm),
    .err     (dec_err)
  );

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign in_ready  = (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Next-state for pointers and occupancy; flush beats push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; the decoded immediate is captured at push time.
  always_ff @(posedge clk) begin
    if (push) begin
      imm_mem_q[wr_ptr_q]  <= dec_imm;
      type_mem_q[wr_ptr_q] <= in_type;
      err_mem_q[wr_ptr_q]  <= dec_err;
    end
  end

  // Head entry, forced to zero while empty.
  assign out_imm  = out_valid ? imm_mem_q[rd_ptr_q]  : '0;
  assign out_type = out_valid ? type_mem_q[rd_ptr_q] : '0;
  assign out_err  = out_valid ? err_mem_q[rd_ptr_q]  : 1'b0;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Self-checking bench for imm_gen_stage (XLEN=32 and XLEN=64 instances, DEPTH=2).
module tb_imm_gen_stage;
  import imm_gen_stage_pkg::*;

  localparam int DEPTH = 2;

  logic            clk;
  logic            rst, flush, in_valid, out_ready;
  logic [31:0]     in_inst;
  type_bus_t       in_type;
  logic            in_ready, out_valid, out_err;
  logic [31:0]     out_imm;
  type_bus_t       out_type;
  logic            in_ready64, out_valid64, out_err64;
  logic [63:0]     out_imm64;
  type_bus_t       out_type64;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [63:0] imm;
    type_bus_t   typ;
    logic        err;
  } ent_t;
  ent_t model_q[$];

  imm_gen_stage #(.XLEN(32), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_type(in_type), .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_type(out_type), .out_err(out_err)
  );

  imm_gen_stage #(.XLEN(64), .DEPTH(DEPTH)) u_dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_inst(in_inst), .in_type(in_type), .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_type(out_type64), .out_err(out_err64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference immediate computed arithmetically from the field weights.
  function automatic logic [63:0] ref_imm(input logic [31:0] inst, input type_bus_t t,
                                          output logic err);
    longint s;
    longint r;
    s   = longint'($signed(inst));
    r   = 0;
    err = 1'b0;
    case (t)
      INST_R: r = 0;
      INST_I: r = s >>> 20;
      INST_S: r = (s >>> 25) * 32 + longint'(inst[11:7]);
      INST_B: r = (s >>> 31) * 4096 + longint'(inst[7]) * 2048
                + longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2;
      INST_U: r = (s >>> 12) * 4096;
      INST_J: r = (s >>> 31) * 1048576 + longint'(inst[19:12]) * 4096
                + longint'(inst[20]) * 2048 + longint'(inst[30:21]) * 2;
`ifdef IMM_GEN_ZICSR_EN
      INST_CSR: r = longint'(inst[19:15]);
`endif
      default: begin r = 0; err = 1'b1; end
    endcase
    return r;
  endfunction

  // Drive one cycle of inputs (called at negedge), update the model, advance to next negedge.
  task automatic drive(input logic iv, input logic [31:0] inst, input type_bus_t t,
                       input logic ordy, input logic fl, input logic rs);
    ent_t e;
    logic er;
    logic do_push, do_pop;
    rst = rs; flush = fl; in_valid = iv; in_inst = inst; in_type = t; out_ready = ordy;
    do_push = iv && (model_q.size() < DEPTH);
    do_pop  = ordy && (model_q.size() > 0);
    if (rs || fl) begin
      model_q.delete();
    end else begin
      if (do_pop) void'(model_q.pop_front());
      if (do_push) begin
        e.imm = ref_imm(inst, t, er);
        e.err = er;
        e.typ = t;
        model_q.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1'b0, 32'h0, INST_R, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 32'h0, INST_R, 1'b0, 1'b0, 1'b0);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++; if (out_imm !== 32'h0 || out_type !== 3'd0 || out_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs got imm=%h type=%0d err=%b want 0", out_imm, out_type, out_err); end
  endtask

  task automatic test_basic_formats();
    logic [31:0] insts [5];
    type_bus_t   types [5];
    logic [31:0] exps  [5];
    insts = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h123452B7, 32'h001000EF};
    types = '{INST_I, INST_S, INST_B, INST_U, INST_J};
    exps  = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000, 32'h00000800};
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 32'h0, INST_R, 1'b1, 1'b0, 1'b0);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fmt%0d_empty got %b want 0", i, out_valid); end
      drive(1'b1, insts[i], types[i], 1'b1, 1'b0, 1'b0);
      n_checks++; if (out_valid !== 1'b1 || out_imm !== exps[i] || out_err !== 1'b0 || out_type !== types[i]) begin
        n_fail++; $display("FAIL fmt%0d_imm got v=%b imm=%h err=%b type=%0d want v=1 imm=%h err=0 type=%0d",
                           i, out_valid, out_imm, out_err, out_type, exps[i], types[i]); end
      if (i == 0) begin
        n_checks++; if (out_imm64 !== 64'hFFFFFFFFFFFFFFFF) begin
          n_fail++; $display("FAIL fmt_i_xlen64 got %h want ffffffffffffffff", out_imm64); end
      end
    end
    drive(1'b0, 32'h0, INST_R, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    logic [31:0] got[$];
    logic        c_taken, sent_now;
    drive(1'b1, 32'h00100093, INST_I, 1'b0, 1'b0, 1'b0);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after1 got %b want 1", in_ready); end
    drive(1'b1, 32'h00200093, INST_I, 1'b0, 1'b0, 1'b0);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_after2 got %b want 0", in_ready); end
    drive(1'b1, 32'h00300093, INST_I, 1'b0, 1'b0, 1'b0);
    n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_imm !== 32'd1) begin
      n_fail++; $display("FAIL bp_hold got ready=%b v=%b imm=%h want ready=0 v=1 imm=1", in_ready, out_valid, out_imm); end
    c_taken = 1'b0;
    for (int cyc = 0; cyc < 20 && got.size() < 3; cyc++) begin
      if (out_valid) got.push_back(out_imm);
      sent_now = in_ready && !c_taken;
      drive(!c_taken, 32'h00300093, INST_I, 1'b1, 1'b0, 1'b0);
      c_taken = c_taken | sent_now;
    end
    n_checks++; if (got.size() != 3) begin n_fail++; $display("FAIL bp_drain_count got %0d want 3", got.size()); end
    for (int i = 0; i < got.size() && i < 3; i++) begin
      n_checks++; if (got[i] !== 32'(i + 1)) begin n_fail++; $display("FAIL bp_order%0d got %h want %h", i, got[i], i + 1); end
    end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup got v=%b want 0", out_valid); end
  endtask

  task automatic test_simultaneous_flush();
    drive(1'b1, 32'h00500093, INST_I, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h00600093, INST_I, 1'b1, 1'b0, 1'b0);
    n_checks++; if (out_valid !== 1'b1 || out_imm !== 32'd6 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL pushpop_advance got v=%b imm=%h ready=%b want v=1 imm=6 ready=1", out_valid, out_imm, in_ready); end
    drive(1'b0, 32'h0, INST_R, 1'b0, 1'b0, 1'b0);
    n_checks++; if (out_imm !== 32'd6) begin n_fail++; $display("FAIL pushpop_stable got %h want 6", out_imm); end
    drive(1'b0, 32'h0, INST_R, 1'b1, 1'b0, 1'b0);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pushpop_count1 got v=%b want 0", out_valid); end
    drive(1'b1, 32'h00700093, INST_I, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h00800093, INST_I, 1'b0, 1'b1, 1'b0);
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_push got v=%b ready=%b want v=0 ready=1", out_valid, in_ready); end
    drive(1'b0, 32'h0, INST_R, 1'b1, 1'b0, 1'b0);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_lost got v=%b want 0", out_valid); end
  endtask

  task automatic test_error_config();
    drive(1'b1, 32'hFFF00093, 3'd7, 1'b1, 1'b0, 1'b0);
    n_checks++; if (out_valid !== 1'b1 || out_err !== 1'b1 || out_imm !== 32'h0 || out_type !== 3'd7) begin
      n_fail++; $display("FAIL err_unsupported got v=%b err=%b imm=%h type=%0d want v=1 err=1 imm=0 type=7",
                         out_valid, out_err, out_imm, out_type); end
    drive(1'b1, 32'h800F8073, INST_CSR, 1'b1, 1'b0, 1'b0);
`ifdef IMM_GEN_ZICSR_EN
    n_checks++; if (out_err !== 1'b0 || out_imm !== 32'h1F || out_imm64 !== 64'h1F) begin
      n_fail++; $display("FAIL csr_uimm got err=%b imm=%h imm64=%h want err=0 imm=1f", out_err, out_imm, out_imm64); end
`else
    n_checks++; if (out_err !== 1'b1 || out_imm !== 32'h0) begin
      n_fail++; $display("FAIL csr_disabled got err=%b imm=%h want err=1 imm=0", out_err, out_imm); end
`endif
    drive(1'b0, 32'h0, INST_R, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h00100093, INST_I, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h00200093, INST_I, 1'b0, 1'b0, 1'b0);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_full_pre got ready=%b want 0", in_ready); end
    drive(1'b1, 32'h00300093, INST_I, 1'b1, 1'b0, 1'b1);
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_full got v=%b ready=%b want v=0 ready=1", out_valid, in_ready); end
  endtask

  task automatic test_random();
    logic        exp_v;
    logic [63:0] exp_imm;
    type_bus_t   exp_t;
    logic        exp_e;
    for (int cyc = 0; cyc < 400; cyc++) begin
      exp_v   = (model_q.size() != 0);
      exp_imm = exp_v ? model_q[0].imm : 64'h0;
      exp_t   = exp_v ? model_q[0].typ : 3'd0;
      exp_e   = exp_v ? model_q[0].err : 1'b0;
      n_checks++;
      if (out_valid !== exp_v || in_ready !== (model_q.size() < DEPTH) || out_imm !== exp_imm[31:0] ||
          out_type !== exp_t || out_err !== exp_e) begin
        n_fail++; $display("FAIL rand%0d got v=%b r=%b imm=%h t=%0d e=%b want v=%b imm=%h t=%0d e=%b",
                           cyc, out_valid, in_ready, out_imm, out_type, out_err, exp_v, exp_imm[31:0], exp_t, exp_e);
      end
      n_checks++;
      if (out_valid64 !== exp_v || out_imm64 !== exp_imm || out_err64 !== exp_e) begin
        n_fail++; $display("FAIL rand64_%0d got v=%b imm=%h e=%b want v=%b imm=%h e=%b",
                           cyc, out_valid64, out_imm64, out_err64, exp_v, exp_imm, exp_e);
      end
      drive(1'($urandom_range(0, 3) != 0), $urandom, 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 63) == 0));
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_type = INST_R; out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic_formats();
    test_backpressure();
    test_simultaneous_flush();
    test_error_config();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
